// File: rtl/gray_pkg.sv
// Shared types and width-generic Gray/binary conversions for the Gray-count receive path.
// Conversions operate on GRAY_MAX_W bits; callers zero-extend and truncate to their own width.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {PRIME, LOCKING, LOCKED} mon_state_t;
  typedef enum logic [1:0] {HOLD, UP, DN, ERR} step_t;

  // Zero bits above the caller's width leave the prefix-XOR unchanged, so one function serves all widths.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_cnt_rx_monitor_sync.sv
// Input synchroniser for the Gray count: STAGES-deep flop chain, cleared by synchronous reset.
// Latency STAGES cycles; no backpressure.
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge i_clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_cnt_rx_monitor.sv
// Gray-count receive monitor: synchronise, decode, classify each step, track lock, count errors.
// Latency gray_in -> bin_out/strobes is SYNC_STAGES+1 cycles; no backpressure (free-running sampler).
module gray_cnt_rx_monitor
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int ALLOW_DOWN  = 0,
  parameter int ERR_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  step_up,
  output logic                  step_dn,
  output logic                  step_err,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);
  localparam logic [7:0]            LOCK_CNT_V = 8'(LOCK_CNT);

  logic [DATA_WIDTH-1:0] gs;
  logic [DATA_WIDTH-1:0] gb;
  logic [DATA_WIDTH-1:0] ref_q;
  step_t                 cls;
  mon_state_t            state_q, state_nxt;
  logic [7:0]            good_q, good_nxt;
  logic                  up_nxt, dn_nxt, err_nxt;

  gray_sync #(.W(DATA_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .rst   (rst),
    .d     (gray_in),
    .q     (gs)
  );

  assign gb = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gs)));

  // Comparisons are DATA_WIDTH wide, so ref+1 / ref-1 wrap modulo 2^DATA_WIDTH.
  always_comb begin
    cls = ERR;
    if (gb == ref_q)              cls = HOLD;
    else if (gb == ref_q + ONE)   cls = UP;
    else if (gb == ref_q - ONE)   cls = (ALLOW_DOWN != 0) ? DN : ERR;
  end

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    up_nxt    = 1'b0;
    dn_nxt    = 1'b0;
    err_nxt   = 1'b0;
    unique case (state_q)
      PRIME: state_nxt = LOCKING;
      LOCKING: begin
        if (cls == UP || cls == DN) begin
          good_nxt = good_q + 8'd1;
          if (good_q + 8'd1 == LOCK_CNT_V) state_nxt = LOCKED;
        end else if (cls == ERR) begin
          good_nxt = '0;
        end
      end
      LOCKED: begin
        if (cls == ERR) begin
          state_nxt = LOCKING;
          good_nxt  = '0;
        end
      end
      default: state_nxt = PRIME;
    endcase
    if (state_q != PRIME) begin
      up_nxt  = (cls == UP);
      dn_nxt  = (cls == DN);
      err_nxt = (cls == ERR);
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= PRIME;
      good_q  <= '0;
    end else begin
      state_q <= state_nxt;
      good_q  <= good_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      bin_out <= '0;
      ref_q   <= '0;
    end else begin
      bin_out <= gb;
      ref_q   <= gb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      step_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      step_up  <= up_nxt;
      step_dn  <= dn_nxt;
      step_err <= err_nxt;
      locked   <= (state_nxt == LOCKED);
    end
  end

  // Clear wins, but an error landing on the clear cycle is still counted.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= err_nxt ? ERR_W'(1) : '0;
    end else if (err_nxt && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_cnt_rx_monitor.sv
// Directed bench for gray_cnt_rx_monitor: a default instance, an ALLOW_DOWN=1 instance and an
// ERR_W=2 instance share one stimulus stream; outputs are sampled 1 time unit after each rising edge.
module tb_gray_cnt_rx_monitor;

  logic       i_clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       err_clr;

  logic [3:0] a_bin, d_bin, e_bin;
  logic       a_up, a_dn, a_err, a_lk;
  logic       d_up, d_dn, d_err, d_lk;
  logic       e_up, e_dn, e_err, e_lk;
  logic [7:0] a_ec, d_ec;
  logic [1:0] e_ec;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  gray_cnt_rx_monitor dut_a (
    .i_clk(i_clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(a_bin), .step_up(a_up), .step_dn(a_dn), .step_err(a_err),
    .locked(a_lk), .err_cnt(a_ec)
  );

  gray_cnt_rx_monitor #(.ALLOW_DOWN(1)) dut_d (
    .i_clk(i_clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(d_bin), .step_up(d_up), .step_dn(d_dn), .step_err(d_err),
    .locked(d_lk), .err_cnt(d_ec)
  );

  gray_cnt_rx_monitor #(.ERR_W(2)) dut_e (
    .i_clk(i_clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(e_bin), .step_up(e_up), .step_dn(e_dn), .step_err(e_err),
    .locked(e_lk), .err_cnt(e_ec)
  );

  typedef struct {
    logic [3:0] g;
    int         bin;
    logic       up;
    logic       err;
    logic       lk;
    int         ec;
  } vec_t;

  localparam int NV = 33;
  vec_t tv [NV];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] g, input logic clr);
    gray_in = g;
    err_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Gray in, then the outputs seen after that edge (bin_out trails gray_in by two rows).
    tv[0]  = '{4'b0000,  0, 1'b0, 1'b0, 1'b0, 0};
    tv[1]  = '{4'b0001,  0, 1'b0, 1'b0, 1'b0, 0};
    tv[2]  = '{4'b0011,  0, 1'b0, 1'b0, 1'b0, 0};
    tv[3]  = '{4'b0010,  1, 1'b1, 1'b0, 1'b0, 0};
    tv[4]  = '{4'b0110,  2, 1'b1, 1'b0, 1'b0, 0};
    tv[5]  = '{4'b0110,  3, 1'b1, 1'b0, 1'b0, 0};
    tv[6]  = '{4'b0110,  4, 1'b1, 1'b0, 1'b1, 0};
    tv[7]  = '{4'b0111,  4, 1'b0, 1'b0, 1'b1, 0};
    tv[8]  = '{4'b0101,  4, 1'b0, 1'b0, 1'b1, 0};
    tv[9]  = '{4'b0100,  5, 1'b1, 1'b0, 1'b1, 0};
    tv[10] = '{4'b1100,  6, 1'b1, 1'b0, 1'b1, 0};
    tv[11] = '{4'b1101,  7, 1'b1, 1'b0, 1'b1, 0};
    tv[12] = '{4'b1111,  8, 1'b1, 1'b0, 1'b1, 0};
    tv[13] = '{4'b1110,  9, 1'b1, 1'b0, 1'b1, 0};
    tv[14] = '{4'b1010, 10, 1'b1, 1'b0, 1'b1, 0};
    tv[15] = '{4'b1011, 11, 1'b1, 1'b0, 1'b1, 0};
    tv[16] = '{4'b1001, 12, 1'b1, 1'b0, 1'b1, 0};
    tv[17] = '{4'b1000, 13, 1'b1, 1'b0, 1'b1, 0};
    tv[18] = '{4'b0000, 14, 1'b1, 1'b0, 1'b1, 0};
    tv[19] = '{4'b0001, 15, 1'b1, 1'b0, 1'b1, 0};
    tv[20] = '{4'b0011,  0, 1'b1, 1'b0, 1'b1, 0};
    tv[21] = '{4'b0011,  1, 1'b1, 1'b0, 1'b1, 0};
    tv[22] = '{4'b0011,  2, 1'b1, 1'b0, 1'b1, 0};
    tv[23] = '{4'b0101,  2, 1'b0, 1'b0, 1'b1, 0};
    tv[24] = '{4'b0101,  2, 1'b0, 1'b0, 1'b1, 0};
    tv[25] = '{4'b0101,  6, 1'b0, 1'b1, 1'b0, 1};
    tv[26] = '{4'b0100,  6, 1'b0, 1'b0, 1'b0, 1};
    tv[27] = '{4'b1100,  6, 1'b0, 1'b0, 1'b0, 1};
    tv[28] = '{4'b1101,  7, 1'b1, 1'b0, 1'b0, 1};
    tv[29] = '{4'b1111,  8, 1'b1, 1'b0, 1'b0, 1};
    tv[30] = '{4'b1111,  9, 1'b1, 1'b0, 1'b0, 1};
    tv[31] = '{4'b1111, 10, 1'b1, 1'b0, 1'b1, 1};
    tv[32] = '{4'b1111, 10, 1'b0, 1'b0, 1'b1, 1};

    rst     = 1'b1;
    gray_in = 4'b0000;
    err_clr = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("reset bin", int'(a_bin), 0);
    chk("reset strobes", int'({a_up, a_dn, a_err}), 0);
    chk("reset locked", int'(a_lk), 0);
    chk("reset err_cnt", int'(a_ec), 0);
    rst = 1'b0;

    // Count-up, lock, wrap 15->0, illegal jump and relock
    for (int i = 0; i < NV; i++) begin
      step(tv[i].g, 1'b0);
      chk($sformatf("vec%0d bin", i),    int'(a_bin), tv[i].bin);
      chk($sformatf("vec%0d up", i),     int'(a_up),  int'(tv[i].up));
      chk($sformatf("vec%0d dn", i),     int'(a_dn),  0);
      chk($sformatf("vec%0d err", i),    int'(a_err), int'(tv[i].err));
      chk($sformatf("vec%0d locked", i), int'(a_lk),  int'(tv[i].lk));
      chk($sformatf("vec%0d err_cnt", i), int'(a_ec), tv[i].ec);
      chk($sformatf("vec%0d d_locked", i), int'(d_lk), int'(tv[i].lk));
    end

    // Down step 10 -> 9: error without ALLOW_DOWN, legal step with it
    step(4'b1101, 1'b0);
    step(4'b1101, 1'b0);
    step(4'b1101, 1'b0);
    chk("down a bin", int'(a_bin), 9);
    chk("down a step_err", int'(a_err), 1);
    chk("down a locked", int'(a_lk), 0);
    chk("down a err_cnt", int'(a_ec), 2);
    chk("down d step_dn", int'(d_dn), 1);
    chk("down d step_err", int'(d_err), 0);
    chk("down d locked", int'(d_lk), 1);
    chk("down d err_cnt", int'(d_ec), 1);
    chk("down e err_cnt", int'(e_ec), 2);
    step(4'b1101, 1'b0);
    chk("down hold a step_err", int'(a_err), 0);
    chk("down hold d step_dn", int'(d_dn), 0);
    chk("down hold d locked", int'(d_lk), 1);

    // Clear, five errors, saturation of the 2-bit counter, clear racing an error
    step(4'b1101, 1'b1);
    chk("clr e err_cnt", int'(e_ec), 0);
    chk("clr a err_cnt", int'(a_ec), 0);
    step(4'b0000, 1'b0);
    step(4'b1101, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1101, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("sat e err_cnt", int'(e_ec), 3);
    chk("sat a err_cnt", int'(a_ec), 5);
    chk("sat d err_cnt", int'(d_ec), 5);
    step(4'b1101, 1'b0);
    step(4'b1101, 1'b0);
    chk("pre-clr e err_cnt", int'(e_ec), 3);
    step(4'b1101, 1'b1);
    chk("clr+err e step_err", int'(e_err), 1);
    chk("clr+err e err_cnt", int'(e_ec), 1);
    chk("clr+err a err_cnt", int'(a_ec), 1);
    step(4'b1101, 1'b1);
    chk("clr alone e err_cnt", int'(e_ec), 0);
    chk("clr alone a err_cnt", int'(a_ec), 0);

    // Two errors then relock at 13, then reset mid-run
    step(4'b0000, 1'b0);
    step(4'b1101, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1011, 1'b0);
    chk("pre-rst bin", int'(a_bin), 13);
    chk("pre-rst locked", int'(a_lk), 1);
    chk("pre-rst err_cnt", int'(a_ec), 2);
    rst = 1'b1;
    step(4'b1011, 1'b0);
    chk("rst bin", int'(a_bin), 0);
    chk("rst strobes", int'({a_up, a_dn, a_err}), 0);
    chk("rst locked", int'(a_lk), 0);
    chk("rst err_cnt", int'(a_ec), 0);
    chk("rst e err_cnt", int'(e_ec), 0);
    rst = 1'b0;
    step(4'b1011, 1'b0);
    chk("prime strobes", int'({a_up, a_dn, a_err}), 0);
    chk("prime bin", int'(a_bin), 0);
    chk("prime locked", int'(a_lk), 0);
    step(4'b1011, 1'b0);
    chk("post-prime strobes", int'({a_up, a_dn, a_err}), 0);
    chk("post-prime err_cnt", int'(a_ec), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
